pdm_cic_decimator: RTL and testbench
====================================

Name: pdm_cic_decimator

Overview:
- Third-order CIC decimation filter; turns a 1-bit PDM stream into signed 16-bit PCM.
- Sits between the PDM pin sampler/clock generator and the bus-facing PCM register/interrupt logic of the PDM microphone peripheral.
- Runs entirely in the clk domain; PDM bits arrive with a one-cycle sample strobe, so there is no clocking from the PDM clock.
- Provides programmable decimation, output scaling with saturation, and a valid/ready output with overrun flag.

Parameters:
- DEC_MAX, 64, maximum decimation ratio (power of two); sets accumulator width.
- ACC_W, 20, integrator/comb width = 3*log2(DEC_MAX)+2; two's-complement, wraps modulo 2^ACC_W.
- OUT_W, 16, PCM output width.

Ports:
- clk  in  1  system clock (64 MHz nominal).
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  filter enable; low clears filter state.
- pdm_bit  in  1  PDM data bit; valid when pdm_strobe=1.
- pdm_strobe  in  1  one-clk pulse per PDM sample; may be asserted every cycle.
- decim  in  7  decimation ratio R; values <4 are treated as 4, values >64 as 64.
- shift  in  4  arithmetic right shift applied to the comb output before saturation.
- pcm_out  out  16  signed PCM sample.
- pcm_valid  out  1  pcm_out holds an unconsumed sample.
- pcm_ready  in  1  consumer accepts pcm_out this cycle when pcm_valid=1.
- overrun  out  1  sticky; a sample was overwritten before it was consumed.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at a clk edge): integrators, comb delays, decimation counter, warm-up counter, pcm_out=0, pcm_valid=0, overrun=0.
- Input mapping: pdm_bit 1 maps to +1, pdm_bit 0 maps to -1.
- Integrators, on each edge with enable & pdm_strobe, all updated in parallel from old values: i1<=i1+x; i2<=i2+i1; i3<=i3+i2.
- Decimation counter cnt increments per strobe.
  - When cnt==Reff-1: cnt<=0 and a frame pulse is raised.
  - Reff is the clamped decim, latched only at a wrap. A change mid-frame takes effect from the next frame.
- Comb pipeline, where E0 is the edge that sampled the frame-completing strobe:
  - E1: c1=i3-d1, d1<=i3.
  - E2: c2=c1-d2, d2<=c1.
  - E3: c3=c2-d3, d3<=c2.
  - E4: y=c3>>>shift, saturated to [-32768, 32767]; offered to output.
  - pcm_valid is visible after E4, i.e. 4 clk of latency. Reff>=4 guarantees the pipeline never overlaps.
- Warm-up: the first 2 comb results after reset or after enable rises are discarded; the 3rd and later are offered.
- Output handshake:
  - Offered sample with pcm_valid=0, or with pcm_valid=1 & pcm_ready=1: load pcm_out, pcm_valid=1, no overrun.
  - Offered sample with pcm_valid=1 & pcm_ready=0: overwrite pcm_out, set overrun.
  - pcm_ready=1 with no new sample: pcm_valid<=0. pcm_out holds its value.
  - overrun_clr and an overrun event in the same cycle: overrun stays 1 (set wins).
- enable=0 at an edge:
  - Clears integrators, combs, cnt, warm-up counter and in-flight pipeline stages; pcm_valid<=0.
  - pcm_out and overrun hold.
  - Strobes are ignored.
- Steady state for constant input: c3 = ±Reff^3. Reff=64 gives ±262144, which fits ACC_W=20.

Optional Feature:
- Macro PDM_CIC_DCBLOCK_EN.
- Defined:
  - A DC-blocking high-pass stage is inserted after saturation: y[n]=x[n]-x[n-1]+y[n-1]-(y[n-1]>>>8), 16-bit with saturation.
  - Adds 1 clk of latency (5 total).
  - State clears on reset and on enable=0.
- Undefined: the stage is absent; 4 clk of latency; output = saturated comb result.

Decomposition:
- Package pdm_pkg:
  - Constants DEC_MIN=4, DEC_MAX=64, ACC_W, OUT_W, WARMUP=2.
  - Saturation function sat16(ACC_W signed) -> 16-bit signed.
- Sub-module pdm_dc_block: DC blocker, instantiated only under PDM_CIC_DCBLOCK_EN.

Test Plan:
- All-ones PDM, strobe every 8 clk, decim=64, shift=4, pcm_ready=1: after warm-up, pcm_out=16384 each frame; pcm_valid 1 clk wide, 4 clk after the frame's last strobe.
- All-zeros, decim=64, shift=0: pcm_out=-32768 (saturated). All-ones, shift=0: pcm_out=32767.
- Alternating 1/0, decim=8, shift=0: after warm-up, every pcm_out=0. decim=2 behaves as decim=4.
- pcm_ready=0 across two frames: the second sample overwrites the first, overrun=1. overrun_clr pulse clears it. Same-cycle ready and new sample: no overrun.
- decim changed 16->32 mid-frame: the current frame still completes after 16 strobes; the next frame takes 32.
- enable dropped mid-frame, then raised: pcm_valid=0 immediately; the first 2 frames after re-enable produce no output; the 3rd is correct.

Source files
------------

// File: rtl/pdm_pkg.sv
// ============================================================================
// Module  : pdm_pkg
// Brief   : Shared constants and the output saturation helper for the PDM CIC
//           decimator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pdm_pkg;

  localparam int DEC_MIN = 4;
  localparam int DEC_MAX = 64;
  localparam int ACC_W   = 3 * $clog2(DEC_MAX) + 2;
  localparam int OUT_W   = 16;
  localparam int WARMUP  = 2;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[OUT_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[OUT_W-1:0];
    end
    return v[OUT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_dc_block.sv
// ============================================================================
// Module  : pdm_dc_block
// Brief   : First-order DC-blocking high-pass, y = x - x' + y' - (y' >>> 8),
//           saturated to 16 bits; one clock of latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pdm_dc_block
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [OUT_W-1:0] x_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] y_o
);

  localparam int W = OUT_W + 3;

  logic signed [OUT_W-1:0] x_prev_q;
  logic signed [OUT_W-1:0] y_q;
  logic                    valid_q;
  logic signed [W-1:0]     sum_d;

  // Three guard bits hold the worst-case sum of four 16-bit terms.
  assign sum_d = W'($signed(x_i)) - W'(x_prev_q) + W'(y_q) - W'(y_q >>> 8);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      x_prev_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        x_prev_q <= x_i;
        y_q      <= sat16(ACC_W'(sum_d));
      end
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;

endmodule

`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
// ============================================================================
// Module  : pdm_cic_decimator
// Brief   : Third-order CIC decimator, 1-bit PDM in, signed 16-bit PCM out with
//           valid/ready and sticky overrun. Define PDM_CIC_DCBLOCK_EN to add
//           the DC-blocking stage (one extra clock of latency).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pdm_cic_decimator #(
  parameter int DEC_MAX = pdm_pkg::DEC_MAX,
  parameter int ACC_W   = pdm_pkg::ACC_W,
  parameter int OUT_W   = pdm_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             pdm_bit_i,
  input  logic             pdm_strobe_i,
  input  logic [6:0]       decim_i,
  input  logic [3:0]       shift_i,
  output logic [OUT_W-1:0] pcm_out_o,
  output logic             pcm_valid_o,
  input  logic             pcm_ready_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  import pdm_pkg::*;

  typedef logic signed [ACC_W-1:0] acc_t;

  logic [6:0] decim_eff;
  logic [6:0] cnt_q, reff_q;
  logic       step, wrap;
  acc_t       x_in;
  acc_t       i1_q, i2_q, i3_q;
  acc_t       d1_q, d2_q, d3_q;
  acc_t       c1_q, c2_q, c3_q;
  acc_t       y_shift;
  logic       frame_q, v1_q, v2_q, v3_q;
  logic [1:0] warm_q;
  logic       offer;
  logic [OUT_W-1:0] sample;
  logic             out_valid;
  logic [OUT_W-1:0] out_sample;
  logic [OUT_W-1:0] pcm_out_q, pcm_out_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    decim_eff = decim_i;
    if (decim_i < 7'(DEC_MIN)) begin
      decim_eff = 7'(DEC_MIN);
    end else if (decim_i > 7'(DEC_MAX)) begin
      decim_eff = 7'(DEC_MAX);
    end
  end

  assign step = enable_i & pdm_strobe_i;
  assign wrap = step && (cnt_q == reff_q - 7'd1);
  assign x_in = pdm_bit_i ? acc_t'(1) : '1;

  // Disable is treated like reset for the filter; the ratio reloads there too.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable_i) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      cnt_q   <= '0;
      reff_q  <= decim_eff;
      frame_q <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      warm_q  <= '0;
    end else begin
      if (step) begin
        i1_q  <= i1_q + x_in;
        i2_q  <= i2_q + i1_q;
        i3_q  <= i3_q + i2_q;
        cnt_q <= wrap ? 7'd0 : cnt_q + 7'd1;
        if (wrap) begin
          reff_q <= decim_eff;
        end
      end
      frame_q <= wrap;
      v1_q    <= frame_q;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      if (frame_q) begin
        c1_q <= i3_q - d1_q;
        d1_q <= i3_q;
      end
      if (v1_q) begin
        c2_q <= c1_q - d2_q;
        d2_q <= c1_q;
      end
      if (v2_q) begin
        c3_q <= c2_q - d3_q;
        d3_q <= c2_q;
      end
      if (v3_q && (warm_q != 2'(WARMUP))) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  assign offer   = v3_q && (warm_q == 2'(WARMUP));
  assign y_shift = c3_q >>> shift_i;
  assign sample  = sat16(y_shift);

`ifdef PDM_CIC_DCBLOCK_EN
  pdm_dc_block u_dc_block (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (!enable_i),
    .valid_i (offer),
    .x_i     (sample),
    .valid_o (out_valid),
    .y_o     (out_sample)
  );
`else
  assign out_valid  = offer;
  assign out_sample = sample;
`endif

  // A new sample always lands; overrun records that the old one was unread.
  always_comb begin
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = overrun_q;
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    if (!enable_i) begin
      pcm_valid_d = 1'b0;
    end else if (out_valid) begin
      pcm_out_d   = out_sample;
      pcm_valid_d = 1'b1;
      if (pcm_valid_q && !pcm_ready_i) begin
        overrun_d = 1'b1;
      end
    end else if (pcm_ready_i) begin
      pcm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_out_o   = pcm_out_q;
  assign pcm_valid_o = pcm_valid_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
// ============================================================================
// Module  : tb_pdm_cic_decimator
// Brief   : Self-checking bench for pdm_cic_decimator against a frame-level
//           CIC reference model (default build, DC blocker absent).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pdm_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n, en, stb, bitv, rdy, oclr;
  logic [6:0]  dec;
  logic [3:0]  shf;
  logic [15:0] pcm_out;
  logic        pcm_valid, overrun;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_n   = 0;
  logic prev_valid = 1'b0;
  int   rises[$];

  // Reference model state: running sums, frame-end history, output register.
  longint s1, s2, s3, h1, h2, h3;
  int     m_cnt, m_reff, m_nfr;
  logic [15:0] m_out;
  logic   m_valid, m_ovr;
  int     due_q[$];
  longint c3_q[$];

  always #5 clk = ~clk;

  pdm_cic_decimator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (en),
    .pdm_bit_i     (bitv),
    .pdm_strobe_i  (stb),
    .decim_i       (dec),
    .shift_i       (shf),
    .pcm_out_o     (pcm_out),
    .pcm_valid_o   (pcm_valid),
    .pcm_ready_i   (rdy),
    .overrun_o     (overrun),
    .overrun_clr_i (oclr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int clamp_dec(input logic [6:0] d);
    if (d < 7'd4) return 4;
    if (d > 7'd64) return 64;
    return int'(d);
  endfunction

  function automatic longint wrap20(input longint v);
    return (v << 44) >>> 44;
  endfunction

  task automatic clear_filter();
    s1 = 0; s2 = 0; s3 = 0; h1 = 0; h2 = 0; h3 = 0;
    m_cnt = 0; m_nfr = 0; m_reff = clamp_dec(dec);
    due_q.delete(); c3_q.delete();
  endtask

  task automatic model_edge(input int k);
    longint t1, t2, t3, c3, y;
    if (!rst_n) begin
      m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
      clear_filter();
      return;
    end
    if (oclr) m_ovr = 1'b0;
    if (!en) begin
      m_valid = 1'b0;
      clear_filter();
      return;
    end
    if (due_q.size() > 0 && due_q[0] == k) begin
      y = c3_q[0] >>> shf;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_out = 16'(y);
      m_valid = 1'b1;
      void'(due_q.pop_front());
      void'(c3_q.pop_front());
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (stb) begin
      t1 = s1 + (bitv ? 1 : -1);
      t2 = s2 + s1;
      t3 = s3 + s2;
      s1 = t1; s2 = t2; s3 = t3;
      m_cnt++;
      if (m_cnt == m_reff) begin
        m_cnt = 0;
        m_reff = clamp_dec(dec);
        // Third-order comb = third difference of the frame-end integrator.
        c3 = s3 - 3 * h1 + 3 * h2 - h3;
        h3 = h2; h2 = h1; h1 = s3;
        m_nfr++;
        if (m_nfr > 2) begin
          due_q.push_back(k + 4);
          c3_q.push_back(wrap20(c3));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(edge_n);
    #1;
    check("out", {15'd0, pcm_valid, overrun, pcm_out}, {15'd0, m_valid, m_ovr, m_out});
    if (pcm_valid && !prev_valid) rises.push_back(edge_n);
    prev_valid = pcm_valid;
    edge_n++;
  endtask

  function automatic int last_period();
    if (rises.size() < 2) return -1;
    return rises[rises.size()-1] - rises[rises.size()-2];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last_stb, chg_edge, en_edge, dis, dens;
    rst_n = 1'b0; en = 1'b0; stb = 1'b0; bitv = 1'b0;
    dec = 7'd64; shf = 4'd4; rdy = 1'b1; oclr = 1'b0;
    clear_filter();
    m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (3) step();
    check("rst_out", {16'd0, pcm_out}, 32'd0);
    check("rst_valid", {31'd0, pcm_valid}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1; en = 1'b1;

    // All ones, strobe every 8 clk, R=64, shift 4
    rises.delete(); last_stb = 0;
    for (int f = 0; f < 5 * 64 * 8; f++) begin
      stb = (f % 8 == 0); bitv = 1'b1;
      if (stb) last_stb = edge_n;
      step();
    end
    check("ones_s4", {16'd0, pcm_out}, 32'd16384);
    check("ones_rises", rises.size(), 3);
    check("ones_period", last_period(), 512);
    check("ones_latency", (rises.size() > 0) ? rises[rises.size()-1] - last_stb : -1, 4);

    // Saturation both ways, strobe every clock
    shf = 4'd0; bitv = 1'b0; stb = 1'b1;
    repeat (4 * 64) step();
    stb = 1'b0; repeat (8) step();
    check("zeros_s0", {16'd0, pcm_out}, 32'h8000);
    bitv = 1'b1; stb = 1'b1;
    repeat (4 * 64) step();
    stb = 1'b0; repeat (8) step();
    check("ones_s0", {16'd0, pcm_out}, 32'h7fff);

    // Alternating input, R=8 then decim=2 (clamped to 4)
    dec = 7'd8; rises.delete();
    for (int f = 0; f < 12 * 64; f++) begin
      stb = 1'b1; bitv = ~bitv; step();
    end
    check("alt_dec64_8", {16'd0, pcm_out}, 32'd0);
    check("alt_period8", last_period(), 8);
    dec = 7'd2; rises.delete();
    for (int f = 0; f < 12 * 4; f++) begin
      stb = 1'b1; bitv = ~bitv; step();
    end
    stb = 1'b0; repeat (8) step();
    check("alt_dec2", {16'd0, pcm_out}, 32'd0);
    check("dec2_period", last_period(), 4);

    // Overrun: two samples with ready low, then clear, then same-cycle ready
    dec = 7'd16; shf = 4'd4; stb = 1'b1;
    repeat (64) begin bitv = 1'($urandom_range(0, 1)); step(); end
    rdy = 1'b0;
    repeat (40) begin bitv = 1'($urandom_range(0, 1)); step(); end
    stb = 1'b0; repeat (6) step();
    check("ovr_set", {31'd0, overrun}, 32'd1);
    oclr = 1'b1; step(); oclr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    stb = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bitv = 1'($urandom_range(0, 1));
      rdy = (due_q.size() > 0 && due_q[0] == edge_n);
      step();
      if (rdy) break;
    end
    check("ovr_same_cycle", {31'd0, overrun}, 32'd0);
    check("ovr_same_valid", {31'd0, pcm_valid}, 32'd1);
    rdy = 1'b1;

    // Ratio change 16 -> 32 mid-frame
    for (int i = 0; i < 64 && m_cnt != 8; i++) begin
      bitv = 1'($urandom_range(0, 1)); step();
    end
    dec = 7'd32; chg_edge = edge_n; rises.delete();
    repeat (8 + 32 + 32 + 2) begin bitv = 1'($urandom_range(0, 1)); step(); end
    check("chg_first", (rises.size() > 0) ? rises[0] - chg_edge : -1, 11);
    check("chg_period", (rises.size() > 1) ? rises[1] - rises[0] : -1, 32);

    // Enable dropped mid-frame, then restored
    dec = 7'd16; rdy = 1'b0;
    repeat (80) begin bitv = 1'($urandom_range(0, 1)); step(); end
    for (int i = 0; i < 64 && m_cnt != 5; i++) begin
      bitv = 1'($urandom_range(0, 1)); step();
    end
    check("pre_dis_valid", {31'd0, pcm_valid}, 32'd1);
    en = 1'b0; step();
    check("dis_valid", {31'd0, pcm_valid}, 32'd0);
    repeat (3) step();
    en = 1'b1; rdy = 1'b1; rises.delete(); en_edge = edge_n;
    repeat (3 * 16) begin bitv = 1'($urandom_range(0, 1)); step(); end
    stb = 1'b0; repeat (8) step();
    check("reen_rises", rises.size(), 1);
    check("reen_time", (rises.size() > 0) ? rises[0] - en_edge : -1, 51);

    // Randomised traffic
    dis = 0; dens = 50;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) dis = $urandom_range(2, 20);
      en = (dis == 0);
      if (dis > 0) dis--;
      if ($urandom_range(0, 199) == 0) begin
        dec = 7'($urandom_range(0, 127));
        dens = $urandom_range(0, 100);
      end
      if ($urandom_range(0, 99) == 0) shf = 4'($urandom_range(0, 15));
      stb  = ($urandom_range(0, 2) != 0);
      bitv = ($urandom_range(0, 99) < dens);
      rdy  = ($urandom_range(0, 9) < 7);
      oclr = en && ($urandom_range(0, 29) == 0);
      step();
    end

    oclr = 1'b0; rst_n = 1'b0; step();
    check("rst2_out", {16'd0, pcm_out}, 32'd0);
    check("rst2_ovr", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
